uart_tx_sched: RTL and testbench
================================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter STOP_BITS, default 1, number of stop-bit periods per frame; legal values 1 and 2.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 bclk  input  1  one-cycle baud tick from the baud generator; one tick = one bit period.
REQ-005 req0  input  1  requester 0 has a byte to send; level-sensitive.
REQ-006 data0  input  8  requester 0 byte; sampled only in the acceptance cycle.
REQ-007 ack0  output  1  one-cycle pulse: requester 0 byte captured.
REQ-008 req1  input  1  requester 1 has a byte to send; level-sensitive.
REQ-009 data1  input  8  requester 1 byte; sampled only in the acceptance cycle.
REQ-010 ack1  output  1  one-cycle pulse: requester 1 byte captured.
REQ-011 tx  output  1  serial line, 8N1 (or 8N2) framing, LSB first, idle high.
REQ-012 busy  output  1  high while a frame is in progress.
REQ-013 grant  output  1  index of requester owning the current or last frame.

Function
REQ-014 States IDLE, SYNC, START, DATA, STOP; tx, busy, ack0, ack1 and grant are registered.
REQ-015 IDLE: tx=1, busy=0; on a clock edge with req0|req1 high, arbitrate, capture the winner's byte into the shift register, go to SYNC.
REQ-016 Arbitration is round-robin: with only one req high, that requester wins; with both high, the winner is the requester not served last.
REQ-017 Last-served pointer resets to 1, so requester 0 wins the first simultaneous contention.
REQ-018 The winner's ack pulses high for exactly the one cycle following the acceptance edge; grant updates at that same edge; the loser's ack stays 0.
REQ-019 busy rises at the acceptance edge and stays high through the end of STOP.
REQ-020 SYNC: tx=1; wait for bclk; a bclk high in the acceptance cycle itself is ignored; on bclk, tx<=0 and go to START.
REQ-021 START: on bclk, tx<=bit0, bit counter<=0, go to DATA.
REQ-022 DATA: on each bclk, advance to the next bit; after bit7 has been held for one tick, tx<=1 and go to STOP.
REQ-023 STOP: tx=1; count STOP_BITS ticks; on the last, go to IDLE with busy<=0 at the same edge.
REQ-024 Every bit (start, data, stop) lasts exactly one bclk period; tx changes only on edges where bclk=1, except reset.
REQ-025 IDLE lasts at least one cycle between frames; a req held high through the ack is treated as a new request in that IDLE cycle.
REQ-026 req and data changes outside IDLE have no effect on the frame in progress; a req dropped before acceptance is never served.
REQ-027 Frame duration from the acceptance edge: wait to first tick + (9 + STOP_BITS) bclk periods.
REQ-028 bclk arriving on consecutive cycles is legal; each tick advances exactly one bit.

Reset
REQ-029 At a rising edge with rst=1: state<=IDLE, tx<=1, busy<=0, ack0<=0, ack1<=0, grant<=0, last-served<=1, bit counter<=0.
REQ-030 rst has priority over all other inputs, including bclk and req.
REQ-031 Reset mid-frame aborts the frame: tx=1 from the next edge, no ack is issued, and the aborted requester gets no priority credit.

Verification
REQ-032 Single req0, data0=0x55, bclk every 16 cycles -> ack0 one cycle after acceptance; tx = 0,1,0,1,0,1,0,1,0,1, 16 cycles per bit; busy falls after the stop tick.
REQ-033 req0 and req1 both high from reset, data0=0xA0, data1=0x0F, held -> frames alternate 0xA0, 0x0F, 0xA0, ...; grant toggles 0,1,0; each ack is a single cycle.
REQ-034 bclk high in the acceptance cycle -> ignored; start bit begins at the next tick, not that one.
REQ-035 STOP_BITS=2, data=0xFF -> tx low for exactly one tick period, then high for 10 tick periods before busy falls.
REQ-036 rst asserted during DATA bit 3 -> tx=1 and busy=0 at the next edge; the next contention with both reqs is won by requester 0.
REQ-037 req1 pulsed for one cycle while busy -> no ack1 and no frame for requester 1.

Source files
------------

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - two-requester round-robin UART transmitter (8N1/8N2, LSB first)
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   bclk         one-cycle baud tick, one tick per bit period
//   req0, data0  requester 0 request level and byte (byte sampled at acceptance)
//   ack0         one-cycle pulse after requester 0's byte is captured
//   req1, data1  requester 1 request level and byte (byte sampled at acceptance)
//   ack1         one-cycle pulse after requester 1's byte is captured
//   tx           serial line, idle high
//   busy         high from the acceptance edge until the last stop tick
//   grant        requester owning the current or most recent frame

module uart_tx_sched #(
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bclk,
    input  logic       req0,
    input  logic [7:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       ack1,
    output logic       tx,
    output logic       busy,
    output logic       grant
);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    state_t     state, state_d;
    logic [7:0] shreg, shreg_d;
    logic [2:0] cnt, cnt_d;
    logic       last, last_d;
    logic       tx_d, busy_d, ack0_d, ack1_d, grant_d;
    logic       win;

    always_comb begin
        state_d = state;
        shreg_d = shreg;
        cnt_d   = cnt;
        last_d  = last;
        tx_d    = tx;
        busy_d  = busy;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        grant_d = grant;
        // Contention goes to whoever was not served last; a lone request wins outright.
        win     = (req0 & req1) ? ~last : req1;

        case (state)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (req0 | req1) begin
                    shreg_d = win ? data1 : data0;
                    grant_d = win;
                    last_d  = win;
                    ack0_d  = ~win;
                    ack1_d  = win;
                    busy_d  = 1'b1;
                    state_d = SYNC;
                end
            end
            // Only entered after acceptance, so a tick coinciding with acceptance is never seen here.
            SYNC: begin
                if (bclk) begin
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (bclk) begin
                    tx_d    = shreg[0];
                    shreg_d = {1'b0, shreg[7:1]};
                    cnt_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bclk) begin
                    if (cnt == 3'd7) begin
                        tx_d    = 1'b1;
                        cnt_d   = 3'd0;
                        state_d = STOP;
                    end else begin
                        tx_d    = shreg[0];
                        shreg_d = {1'b0, shreg[7:1]};
                        cnt_d   = cnt + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bclk) begin
                    if (cnt == STOP_LAST) begin
                        busy_d  = 1'b0;
                        cnt_d   = 3'd0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            shreg <= 8'd0;
            cnt   <= 3'd0;
            last  <= 1'b1;
            tx    <= 1'b1;
            busy  <= 1'b0;
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            grant <= 1'b0;
        end else begin
            state <= state_d;
            shreg <= shreg_d;
            cnt   <= cnt_d;
            last  <= last_d;
            tx    <= tx_d;
            busy  <= busy_d;
            ack0  <= ack0_d;
            ack1  <= ack1_d;
            grant <= grant_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - self-checking bench for uart_tx_sched (1 and 2 stop bits)

module tb_uart_tx_sched;

    logic       clk = 1'b0;
    logic       rst, bclk, req0, req1;
    logic [7:0] data0, data1;
    logic       ack0_a, ack1_a, tx_a, busy_a, grant_a;
    logic       ack0_b, ack1_b, tx_b, busy_b, grant_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    uart_tx_sched #(.STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .bclk(bclk),
        .req0(req0), .data0(data0), .ack0(ack0_a),
        .req1(req1), .data1(data1), .ack1(ack1_a),
        .tx(tx_a), .busy(busy_a), .grant(grant_a)
    );

    uart_tx_sched #(.STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .bclk(bclk),
        .req0(req0), .data0(data0), .ack0(ack0_b),
        .req1(req1), .data1(data1), .ack1(ack1_b),
        .tx(tx_b), .busy(busy_b), .grant(grant_b)
    );

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: a frame is an array of line levels {stop(s), data LSB first, start};
    // each tick after acceptance steps one position, the tick past the end returns to idle.
    logic        m_busy[2], m_last[2];
    logic        e_tx[2], e_ack0[2], e_ack1[2], e_grant[2];
    logic [10:0] m_lv[2];
    int          m_pos[2];
    logic [10:0] m_tmp;
    logic        m_w;
    int          m_n;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            m_n = (k == 0) ? 10 : 11;
            if (rst) begin
                m_busy[k] = 1'b0; m_last[k] = 1'b1; m_pos[k] = 0;
                e_tx[k] = 1'b1; e_ack0[k] = 1'b0; e_ack1[k] = 1'b0; e_grant[k] = 1'b0;
            end else begin
                e_ack0[k] = 1'b0;
                e_ack1[k] = 1'b0;
                if (!m_busy[k]) begin
                    if (req0 || req1) begin
                        m_w = (req0 && req1) ? !m_last[k] : req1;
                        m_lv[k] = {2'b11, (m_w ? data1 : data0), 1'b0};
                        m_pos[k] = -1;
                        m_busy[k] = 1'b1;
                        m_last[k] = m_w;
                        e_grant[k] = m_w;
                        e_ack0[k] = !m_w;
                        e_ack1[k] = m_w;
                        e_tx[k] = 1'b1;
                    end
                end else if (bclk) begin
                    m_pos[k]++;
                    if (m_pos[k] == m_n) begin
                        m_busy[k] = 1'b0;
                        e_tx[k] = 1'b1;
                    end else begin
                        m_tmp = m_lv[k] >> m_pos[k];
                        e_tx[k] = m_tmp[0];
                    end
                end
            end
        end
    end

    int ack1_cnt = 0;

    always @(negedge clk) begin
        check("dut1_out", {3'b000, tx_a, busy_a, ack0_a, ack1_a, grant_a},
              {3'b000, e_tx[0], m_busy[0], e_ack0[0], e_ack1[0], e_grant[0]});
        check("dut2_out", {3'b000, tx_b, busy_b, ack0_b, ack1_b, grant_b},
              {3'b000, e_tx[1], m_busy[1], e_ack0[1], e_ack1[1], e_grant[1]});
        if (ack1_a) ack1_cnt++;
    end

    int bmode = 0;
    int bper  = 16;
    int bcnt  = 0;

    task automatic cyc();
        @(posedge clk);
        #1;
        if (bmode != 0) begin
            bclk = ($urandom_range(0, 2) == 0);
        end else begin
            bcnt++;
            if (bcnt >= bper) begin
                bcnt = 0;
                bclk = 1'b1;
            end else begin
                bclk = 1'b0;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic rand_run(input int n, input int rst_odds);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 9) == 0) req0 = ~req0;
            if ($urandom_range(0, 9) == 0) req1 = ~req1;
            data0 = 8'($urandom);
            data1 = 8'($urandom);
            rst   = (rst_odds > 0) && ($urandom_range(0, rst_odds - 1) == 0);
            cyc();
        end
        rst  = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    int c0;

    initial begin
        rst = 1'b1; bclk = 1'b0; req0 = 1'b0; req1 = 1'b0; data0 = 8'h00; data1 = 8'h00;
        run(3);
        @(negedge clk);
        check("rst_state_1", {3'b000, tx_a, busy_a, ack0_a, ack1_a, grant_a}, 8'h10);
        check("rst_state_2", {3'b000, tx_b, busy_b, ack0_b, ack1_b, grant_b}, 8'h10);
        rst = 1'b0;

        // Single requester, 0x55, 16 cycles per bit.
        req0 = 1'b1; data0 = 8'h55;
        cyc();
        req0 = 1'b0;
        @(negedge clk);
        check("ack0_pulse", {3'b000, tx_a, busy_a, ack0_a, ack1_a, grant_a}, 8'h1C);
        run(240);

        // Tick coinciding with acceptance must not start the frame.
        cyc();
        req1 = 1'b1; data1 = 8'h3C; bclk = 1'b1; bcnt = 0;
        cyc();
        req1 = 1'b0;
        @(negedge clk);
        check("ack1_pulse", {3'b000, tx_a, busy_a, ack0_a, ack1_a, grant_a}, 8'h1B);
        run(15);
        @(negedge clk);
        check("no_early_start", {7'd0, tx_a}, 8'h01);
        cyc();
        @(negedge clk);
        check("start_bit", {7'd0, tx_a}, 8'h00);
        run(220);

        // Both requesters held from reset: alternating frames, requester 0 first.
        bper = 4;
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; data0 = 8'hA0; data1 = 8'h0F;
        cyc();
        rst = 1'b0;
        cyc();
        @(negedge clk);
        check("rr_first", {3'b000, tx_a, busy_a, ack0_a, ack1_a, grant_a}, 8'h1C);
        run(600);
        req0 = 1'b0; req1 = 1'b0;
        run(120);

        // One-cycle req1 pulse during a frame is never served.
        bper = 8;
        c0 = ack1_cnt;
        req0 = 1'b1; data0 = 8'($urandom);
        cyc();
        req0 = 1'b0;
        run(10);
        req1 = 1'b1;
        cyc();
        req1 = 1'b0;
        run(200);
        check("no_ack1", 8'(ack1_cnt - c0), 8'h00);

        // Reset mid-frame: abort, pointer restored so requester 0 wins contention.
        bper = 4;
        req0 = 1'b1; data0 = 8'hC3;
        cyc();
        req0 = 1'b0;
        run(20);
        rst = 1'b1;
        cyc();
        @(negedge clk);
        check("abort_idle", {3'b000, tx_a, busy_a, ack0_a, ack1_a, grant_a}, 8'h10);
        rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
        cyc();
        @(negedge clk);
        check("abort_rr", {3'b000, tx_a, busy_a, ack0_a, ack1_a, grant_a}, 8'h1C);
        req0 = 1'b0; req1 = 1'b0;
        run(120);

        // Tick on every cycle.
        bper = 1;
        rand_run(400, 0);
        run(40);

        // Random ticks, requests, data and occasional reset.
        bmode = 1;
        rand_run(5000, 500);
        run(120);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
